// File: rtl/xor_accum16_if.sv
// Handshake bundle for xor_accum16: start/seed/len command, input word stream and result port.
// The master side drives commands, input words and out_ready; the slave side is the accumulator.
interface xor_accum16_if #(
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic [15:0]      seed16;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [15:0]      in16;
  logic             in_ready;
  logic             out_valid;
  logic [15:0]      out16;
  logic             out_ready;
  logic             busy;

  modport master (
    output start, seed16, len, in_valid, in16, out_ready,
    input  in_ready, out_valid, out16, busy
  );

  modport slave (
    input  start, seed16, len, in_valid, in16, out_ready,
    output in_ready, out_valid, out16, busy
  );
endinterface

// File: rtl/xor_accum16.sv
// Sequential 16-bit XOR checksum accumulator with valid/ready input and output ports.
// Define XORACC_ROTATE_EN to rotate the accumulator left by one before each XOR.
module xor_accum16 #(
  parameter int unsigned LEN_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  xor_accum16_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      acc_fb;
  logic             beat;

`ifdef XORACC_ROTATE_EN
  assign acc_fb = {acc_q[14:0], acc_q[15]};
`else
  assign acc_fb = acc_q;
`endif

  assign beat = (state_q == StAccum) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d   = bus.seed16;
          cnt_d   = bus.len;
          state_d = (bus.len == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        // cnt_q is always >= 1 here, so the decrement never wraps
        if (beat) begin
          acc_d = acc_fb ^ bus.in16;
          cnt_d = cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
          if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode state only; no combinational path from in_valid/out_ready
  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out16     = acc_q;

endmodule

// File: tb/tb_xor_accum16.sv
// Directed self-checking bench for xor_accum16; expected checksums are hand-computed per build.
module tb_xor_accum16;
  localparam int unsigned LEN_W = 8;

`ifdef XORACC_ROTATE_EN
  localparam logic [15:0] ExpBasic = 16'hB7D0;
  localparam logic [15:0] ExpStall = 16'hEEEE;
  localparam logic [15:0] ExpB2b   = 16'h2323;
  localparam logic [15:0] ExpPost  = 16'h0003;
`else
  localparam logic [15:0] ExpBasic = 16'hED34;
  localparam logic [15:0] ExpStall = 16'hFFFF;
  localparam logic [15:0] ExpB2b   = 16'h1010;
  localparam logic [15:0] ExpPost  = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  xor_accum16_if #(.LEN_W(LEN_W)) bus ();

  xor_accum16 #(.LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [15:0] seed, input logic [LEN_W-1:0] n);
    bus.start  = 1'b1;
    bus.seed16 = seed;
    bus.len    = n;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic beat(input logic [15:0] w);
    bus.in_valid = 1'b1;
    bus.in16     = w;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.seed16   = 16'h0000;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.in16     = 16'h0000;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out16", 32'(bus.out16), 32'h0000);
    rst = 1'b0;

    // Basic packet
    cmd(16'h0000, 8'd3);
    check("basic_in_ready", 32'(bus.in_ready), 32'd1);
    check("basic_busy", 32'(bus.busy), 32'd1);
    beat(16'h1234);
    beat(16'hFFFF);
    check("basic_not_done", 32'(bus.out_valid), 32'd0);
    beat(16'h00FF);
    check("basic_out_valid", 32'(bus.out_valid), 32'd1);
    check("basic_in_ready_lo", 32'(bus.in_ready), 32'd0);
    check("basic_out16", 32'(bus.out16), 32'(ExpBasic));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("basic_idle", 32'(bus.busy), 32'd0);

    // Zero length; an offered word must not be taken
    cmd(16'hA5A5, 8'd0);
    check("zero_out_valid", 32'(bus.out_valid), 32'd1);
    check("zero_out16", 32'(bus.out16), 32'hA5A5);
    check("zero_in_ready", 32'(bus.in_ready), 32'd0);
    beat(16'h5555);
    check("zero_hold", 32'(bus.out16), 32'hA5A5);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("zero_idle", 32'(bus.busy), 32'd0);

    // Input stalls
    cmd(16'h0000, 8'd2);
    beat(16'h0F0F);
    for (int i = 0; i < 4; i++) tick();
    check("stall_in_ready", 32'(bus.in_ready), 32'd1);
    check("stall_out_valid", 32'(bus.out_valid), 32'd0);
    beat(16'hF0F0);
    check("stall_out_valid2", 32'(bus.out_valid), 32'd1);
    check("stall_out16", 32'(bus.out16), 32'(ExpStall));

    // Output backpressure with ignored start pulses
    for (int i = 0; i < 5; i++) begin
      bus.start  = i[0];
      bus.seed16 = 16'h1357;
      bus.len    = 8'd0;
      tick();
      check($sformatf("bp_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_out16_%0d", i), 32'(bus.out16), 32'(ExpStall));
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_idle_busy", 32'(bus.busy), 32'd0);
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);

    // Back-to-back: new start right after the output handshake
    cmd(16'h1111, 8'd1);
    beat(16'h0101);
    check("b2b_out16", 32'(bus.out16), 32'(ExpB2b));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("b2b_idle", 32'(bus.busy), 32'd0);
    cmd(16'h0000, 8'd3);
    check("b2b_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset mid-operation after 1 of 3 words
    beat(16'hBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out16", 32'(bus.out16), 32'h0000);
    cmd(16'h0001, 8'd1);
    beat(16'h0001);
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_out16", 32'(bus.out16), 32'(ExpPost));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_rst_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/xor_accum16.md
# xor_accum16

Sequential 16-bit XOR checksum accumulator. It sits directly downstream of the 16-bit bitwise XOR gate stage: each accepted word is XORed into a running accumulator, which is fed back as the gate stage's other operand. A `start` command loads a seed and a word count. Input words then arrive over a valid/ready handshake. After the last word, the result is presented on a valid/ready output port until it is consumed.

## Interface
Parameters:
- `LEN_W`, default 8: width of the word-count field; maximum packet length is 2^LEN_W − 1 words.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. Begin a packet; sampled only in IDLE.
- `seed16`: input, 16 bits. Initial accumulator value, captured with `start`.
- `len`: input, LEN_W bits. Number of words in the packet, captured with `start`.
- `in_valid`: input, 1 bit. Upstream word present.
- `in16`: input, 16 bits. Upstream data word.
- `in_ready`: output, 1 bit. Block accepts a word this cycle.
- `out_valid`: output, 1 bit. Checksum available.
- `out16`: output, 16 bits. Checksum value.
- `out_ready`: input, 1 bit. Downstream consumes the checksum.
- `busy`: output, 1 bit. High in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, DONE. Encoding is free.
- Output decode per state:
  - IDLE: `in_ready`=0, `out_valid`=0, `busy`=0.
  - ACCUM: `in_ready`=1, `out_valid`=0, `busy`=1.
  - DONE: `in_ready`=0, `out_valid`=1, `busy`=1.
- IDLE + `start`=1: load `acc` ← `seed16` and `cnt` ← `len`.
  - `len`=0: go to DONE.
  - `len`≠0: go to ACCUM.
- ACCUM, beat accepted (`in_valid`=1 and `in_ready`=1):
  - `acc` ← f(`acc`) XOR `in16`.
  - `cnt` ← `cnt` − 1.
  - If `cnt` was 1, go to DONE.
- ACCUM, no beat (`in_valid`=0): no state change. Gaps are not counted.
- DONE: `out16` = `acc`, held stable while `out_valid`=1. If `out_ready`=1, go to IDLE.
- `out16` outside DONE: drives `acc`; consumers must qualify it with `out_valid`.
- `start` in ACCUM or DONE: ignored; no queuing.
- f(`acc`) = `acc` by default (see Configuration).
- Arithmetic: `cnt` is LEN_W bits and is decremented only in ACCUM, where it is ≥1. It never wraps.

## Timing
- Reset (`rst`=1 at a clock edge), with priority over every other input:
  - state ← IDLE, `acc` ← 16'h0000, `cnt` ← 0.
  - `in_ready`=0, `out_valid`=0, `busy`=0, `out16`=16'h0000.
- Reset mid-operation discards the packet. No partial result is emitted.
- Start to ready: `start` sampled in cycle T gives `in_ready`=1 in cycle T+1.
- Zero-length packet: `start` with `len`=0 in cycle T gives `out_valid`=1 in cycle T+1.
- Throughput: one word per cycle while `in_valid` stays high.
- Last word to result: last beat in cycle T gives `out_valid`=1 in cycle T+1.
- Output handshake completes in the same cycle `out_valid` and `out_ready` are both 1. The block is in IDLE the next cycle.
- Earliest next packet: a new `start` can be accepted one cycle after the output handshake. Minimum packet-to-packet gap is therefore 2 cycles.
- Output registers: `in_ready`, `out_valid` and `busy` decode state only. They have no combinational path from `in_valid` or `out_ready`.

## Configuration
- Macro `XORACC_ROTATE_EN`.
  - Defined: f(`acc`) = {`acc`[14:0], `acc`[15]}, i.e. rotate left by 1 before each XOR. This gives a rotating XOR checksum that detects word reordering.
  - Undefined: f(`acc`) = `acc`, a plain XOR checksum.
- Seed load, zero-length handling and all timing are identical in both builds.

## Test plan
- Basic packet: `seed16`=0x0000, `len`=3, words 0x1234, 0xFFFF, 0x00FF.
  - Plain build: `out16`=0xED34.
  - `XORACC_ROTATE_EN` build: `out16`=0xB7D0.
  - In both builds `out_valid` rises 1 cycle after the third beat.
- Zero length: `seed16`=0xA5A5, `len`=0. `out_valid`=1 with `out16`=0xA5A5 one cycle after `start`; no beat is accepted.
- Input stalls: `len`=2, words 0x0F0F and 0xF0F0, `in_valid` low for 4 cycles between them. `out16`=0xFFFF in the plain build; exactly 2 beats are counted.
- Output backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - `out_valid` and `out16` stay stable.
  - `start` pulses are ignored.
  - After `out_ready`=1, the block is in IDLE the next cycle.
- Reset mid-operation: assert `rst` after 1 of 3 words.
  - Next cycle: `busy`=0, `in_ready`=0, `out16`=0x0000.
  - A new packet (seed 0x0001, `len`=1, word 0x0001) then yields 0x0000 in the plain build.
- Back-to-back packets: a second `start` in the cycle after the output handshake is accepted, and `in_ready` rises 1 cycle later.
